// File: rtl/lcd_scan_out_if.sv
// IRB read-port and pixel-stream signal bundle for lcd_scan_out.
// master = scan-out engine side, slave = memory/panel side.
interface lcd_scan_out_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [DW-1:0] IRB_Q;
  logic          IRB_CEN;
  logic          IRB_WEN;
  logic [AW-1:0] IRB_A;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          line_start;
  logic          frame_end;

  modport master (
    input  IRB_Q, pix_ready,
    output IRB_CEN, IRB_WEN, IRB_A, pix_data, pix_valid, line_start, frame_end
  );

  modport slave (
    output IRB_Q, pix_ready,
    input  IRB_CEN, IRB_WEN, IRB_A, pix_data, pix_valid, line_start, frame_end
  );
endinterface

// File: rtl/lcd_scan_out.sv
// Reads the IMG_WxIMG_H image out of IRB in raster order; first beat 3 cycles after start, then 1/cycle.
// pix_ready low stalls a 2-entry skid buffer and throttles IRB reads; LCD_SCAN_CRC_EN adds frame_crc.
module lcd_scan_out #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8,
  parameter int AW    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  lcd_scan_out_if.master  bus,
  output logic            busy
`ifdef LCD_SCAN_CRC_EN
  ,
  output logic [7:0]      frame_crc
`endif
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          ls;
    logic          fe;
  } beat_t;

  state_t        state, state_nxt;
  beat_t         ent0, ent1, cap;
  logic [1:0]    cnt, cnt_nxt;
  logic          valid_q;
  logic          infl, infl_ls, infl_fe;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] col;
  logic          hs, rd, accept;

  assign hs      = valid_q && bus.pix_ready;
  assign accept  = (state == IDLE) && start;
  assign cap     = {bus.IRB_Q, infl_ls, infl_fe};
  // occupancy after this cycle's handshake/capture, with the in-flight read folded in
  assign cnt_nxt = cnt + {1'b0, infl} - {1'b0, hs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // The read strobe looks at this cycle's handshake so a 2-deep buffer sustains 1 beat/cycle.
  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        rd = (cnt_nxt < 2'd2);
        if (rd && rd_addr == LAST_ADDR) state_nxt = DRAIN;
      end
      DRAIN: if (hs && ent0.fe) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      rd_addr <= '0;
      col     <= '0;
      infl    <= 1'b0;
      infl_ls <= 1'b0;
      infl_fe <= 1'b0;
      ent0    <= '0;
      ent1    <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      valid_q <= (cnt_nxt != 2'd0);
      infl    <= rd;
      if (accept) begin
        busy    <= 1'b1;
        rd_addr <= '0;
        col     <= '0;
      end else begin
        if (state == DRAIN && hs && ent0.fe) busy <= 1'b0;
        if (rd) begin
          rd_addr <= rd_addr + 1'b1;
          col     <= (col == LAST_COL) ? '0 : col + 1'b1;
        end
      end
      if (rd) begin
        infl_ls <= (col == '0);
        infl_fe <= (rd_addr == LAST_ADDR);
      end
      case ({infl, hs})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= cap;
          else             ent1 <= cap;
        end
        2'b01: ent0 <= ent1;
        2'b11: begin
          if (cnt == 2'd1) ent0 <= cap;
          else begin
            ent0 <= ent1;
            ent1 <= cap;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.IRB_CEN    = ~rd;
  assign bus.IRB_WEN    = 1'b1;
  assign bus.IRB_A      = rd_addr;
  assign bus.pix_data   = ent0.dat;
  assign bus.line_start = ent0.ls;
  assign bus.frame_end  = ent0.fe;
  assign bus.pix_valid  = valid_q;

`ifdef LCD_SCAN_CRC_EN
  // CRC-8 poly 0x07, MSB first, one pixel per handshake
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [DW-1:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  logic [7:0] crc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      crc <= 8'h00;
    else if (accept) crc <= 8'h00;
    else if (hs)     crc <= crc8_step(crc, ent0.dat);
  end
  assign frame_crc = crc;
`endif
endmodule
